// File: rtl/qe_signal_emulator_if.sv
`default_nettype none
// ============================================================================
// Module      : qe_signal_emulator_if
// Description : Command handshake bundle for the quadrature encoder emulator.
//               QE_EMU_CONTINUOUS_EN adds the cmd_continuous request bit.
// Revision    : 1.0 - initial release
// ============================================================================
interface qe_signal_emulator_if #(
    parameter int POS_W  = 32,
    parameter int TIME_W = 24,
    parameter int REV_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [POS_W-1:0]  cmd_steps;
    logic [TIME_W-1:0] cmd_phase_time;
    logic [REV_W-1:0]  counts_per_rev;
    logic              abort;
`ifdef QE_EMU_CONTINUOUS_EN
    logic              cmd_continuous;

    modport master (
        output cmd_valid, cmd_steps, cmd_phase_time, counts_per_rev, abort, cmd_continuous,
        input  cmd_ready
    );
    modport slave (
        input  cmd_valid, cmd_steps, cmd_phase_time, counts_per_rev, abort, cmd_continuous,
        output cmd_ready
    );
`else
    modport master (
        output cmd_valid, cmd_steps, cmd_phase_time, counts_per_rev, abort,
        input  cmd_ready
    );
    modport slave (
        input  cmd_valid, cmd_steps, cmd_phase_time, counts_per_rev, abort,
        output cmd_ready
    );
`endif
endinterface
`default_nettype wire

// File: rtl/qe_signal_emulator.sv
`default_nettype none
// ============================================================================
// Module      : qe_signal_emulator
// Description : Quadrature encoder transmitter producing A/B/I waveforms from
//               move commands. Optional: QE_EMU_CONTINUOUS_EN (endless moves).
// Revision    : 1.0 - initial release
// ============================================================================
module qe_signal_emulator #(
    parameter int POS_W  = 32,
    parameter int TIME_W = 24,
    parameter int REV_W  = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    qe_signal_emulator_if.slave    cmd_if,
    output logic                   QE_A,
    output logic                   QE_B,
    output logic                   QE_I,
    output logic                   busy,
    output logic [POS_W-1:0]       position,
    output logic                   done_pulse
);
    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]        r_state;
    logic [1:0]        r_phase;
    logic [REV_W-1:0]  r_rev;
    logic [REV_W-1:0]  r_cpr;
    logic [TIME_W-1:0] r_timer;
    logic [TIME_W-1:0] r_ptime;
    logic [POS_W-1:0]  r_remaining;
    logic [POS_W-1:0]  r_pos;
    logic              r_dir;
    logic              r_cont;
    logic              r_a, r_b, r_i;
    logic              r_busy, r_ready, r_done;

    logic              w_accept;
    logic              w_cont_cmd;
    logic [POS_W-1:0]  w_mag;
    logic [TIME_W-1:0] w_ptime;
    logic [1:0]        w_phase_nx;
    logic [REV_W-1:0]  w_rev_nx;
    logic              w_last;

`ifdef QE_EMU_CONTINUOUS_EN
    assign w_cont_cmd = cmd_if.cmd_continuous;
`else
    assign w_cont_cmd = 1'b0;
`endif

    assign w_accept   = cmd_if.cmd_valid && r_ready;
    // Two's-complement negation also yields 2^(POS_W-1) for the most negative value
    assign w_mag      = cmd_if.cmd_steps[POS_W-1] ? (~cmd_if.cmd_steps + POS_W'(1))
                                                  : cmd_if.cmd_steps;
    assign w_ptime    = (cmd_if.cmd_phase_time == '0) ? TIME_W'(1) : cmd_if.cmd_phase_time;
    assign w_phase_nx = r_dir ? (r_phase + 2'd1) : (r_phase - 2'd1);
    assign w_last     = !r_cont && (r_remaining == POS_W'(1));

    always_comb begin
        w_rev_nx = r_rev;
        if (r_cpr != '0) begin
            if (r_dir)
                w_rev_nx = (r_rev >= r_cpr - REV_W'(1)) ? '0 : r_rev + REV_W'(1);
            else
                w_rev_nx = (r_rev == '0) ? r_cpr - REV_W'(1) : r_rev - REV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_phase     <= 2'd0;
            r_rev       <= '0;
            r_cpr       <= '0;
            r_timer     <= '0;
            r_ptime     <= '0;
            r_remaining <= '0;
            r_pos       <= '0;
            r_dir       <= 1'b1;
            r_cont      <= 1'b0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_i         <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        if ((w_mag == '0) && !w_cont_cmd) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state     <= c_RUN;
                            r_ready     <= 1'b0;
                            r_busy      <= 1'b1;
                            r_remaining <= w_mag;
                            r_dir       <= !cmd_if.cmd_steps[POS_W-1];
                            r_cont      <= w_cont_cmd;
                            r_ptime     <= w_ptime;
                            r_timer     <= w_ptime;
                            r_cpr       <= cmd_if.counts_per_rev;
                        end
                    end
                end
                c_RUN: begin
                    // Abort wins over an edge due on the same cycle
                    if (cmd_if.abort) begin
                        r_state <= c_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (r_timer == TIME_W'(1)) begin
                        r_phase <= w_phase_nx;
                        r_a     <= w_phase_nx[1] ^ w_phase_nx[0];
                        r_b     <= w_phase_nx[1];
                        r_pos   <= r_dir ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
                        r_rev   <= w_rev_nx;
                        r_i     <= (r_cpr != '0) && (w_rev_nx == '0);
                        r_timer <= r_ptime;
                        if (!r_cont)
                            r_remaining <= r_remaining - POS_W'(1);
                        if (w_last) begin
                            r_state <= c_IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer - TIME_W'(1);
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign cmd_if.cmd_ready = r_ready;
    assign QE_A             = r_a;
    assign QE_B             = r_b;
    assign QE_I             = r_i;
    assign busy             = r_busy;
    assign position         = r_pos;
    assign done_pulse       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_qe_signal_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_qe_signal_emulator
// Description : Self-checking bench for qe_signal_emulator against an
//               edge-level reference model. Honours QE_EMU_CONTINUOUS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qe_signal_emulator;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        QE_A, QE_B, QE_I, busy, done_pulse;
    logic [31:0] position;

    int n_assert = 0;
    int n_fail   = 0;

    int          m_phase = 0;
    int          m_rev   = 0;
    int          m_cpr   = 0;
    logic [31:0] m_pos   = '0;
    logic        m_idx   = 1'b0;
    logic [1:0]  ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    always #5 clk = ~clk;

    qe_signal_emulator_if #(.POS_W(32), .TIME_W(24), .REV_W(16)) bus ();

    qe_signal_emulator #(.POS_W(32), .TIME_W(24), .REV_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_if     (bus),
        .QE_A       (QE_A),
        .QE_B       (QE_B),
        .QE_I       (QE_I),
        .busy       (busy),
        .position   (position),
        .done_pulse (done_pulse)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input bit exp_busy, input bit exp_done);
        check({tag, ".ab"},    {62'd0, QE_A, QE_B}, {62'd0, ab_tab[m_phase]});
        check({tag, ".idx"},   {63'd0, QE_I}, {63'd0, m_idx});
        check({tag, ".pos"},   {32'd0, position}, {32'd0, m_pos});
        check({tag, ".busy"},  {63'd0, busy}, {63'd0, exp_busy});
        check({tag, ".ready"}, {63'd0, bus.cmd_ready}, {63'd0, !exp_busy});
        check({tag, ".done"},  {63'd0, done_pulse}, {63'd0, exp_done});
    endtask

    task automatic model_edge(input bit cw);
        m_phase = (m_phase + (cw ? 1 : 3)) % 4;
        m_pos   = cw ? m_pos + 32'd1 : m_pos - 32'd1;
        if (m_cpr != 0) begin
            m_rev = cw ? (m_rev + 1) % m_cpr : (m_rev + m_cpr - 1) % m_cpr;
            m_idx = (m_rev == 0);
        end else begin
            m_idx = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_rev = 0; m_pos = '0; m_idx = 1'b0;
    endtask

    // One command: abort_after >= 0 raises abort once that many edges have been seen
    task automatic do_move(input int steps, input int pt, input int cpr,
                           input int abort_after, input bit cont, input bit abort_acc);
        longint a;
        longint n;
        int     p;
        bit     cw;
        int     edges;
        int     t;
        a     = steps;
        n     = (a < 0) ? -a : a;
        p     = (pt == 0) ? 1 : pt;
        cw    = (steps >= 0);
        edges = 0;
        t     = 0;
        @(negedge clk);
        bus.cmd_valid      = 1'b1;
        bus.cmd_steps      = steps;
        bus.cmd_phase_time = 24'(pt);
        bus.counts_per_rev = 16'(cpr);
        bus.abort          = abort_acc;
`ifdef QE_EMU_CONTINUOUS_EN
        bus.cmd_continuous = cont;
`endif
        @(posedge clk); #1;
        bus.cmd_valid      = 1'b0;
        bus.abort          = 1'b0;
        bus.cmd_steps      = $urandom;
        bus.cmd_phase_time = 24'($urandom);
        bus.counts_per_rev = 16'($urandom);
`ifdef QE_EMU_CONTINUOUS_EN
        bus.cmd_continuous = 1'($urandom);
`endif
        m_cpr = cpr;
        if (n == 0 && !cont) begin
            check_outputs("zero", 1'b0, 1'b1);
            @(posedge clk); #1;
            check_outputs("zero_after", 1'b0, 1'b0);
            return;
        end
        check_outputs("start", 1'b1, 1'b0);
        while (1) begin
            if (abort_after >= 0 && edges == abort_after) begin
                bus.abort = 1'b1;
                @(posedge clk); #1;
                bus.abort = 1'b0;
                check_outputs("abort", 1'b0, 1'b0);
                @(posedge clk); #1;
                check_outputs("abort_hold", 1'b0, 1'b0);
                break;
            end
            @(posedge clk); #1;
            t++;
            if (t % p == 0) begin
                edges++;
                model_edge(cw);
            end
            if (!cont && edges == n) begin
                check_outputs("final_edge", 1'b0, 1'b1);
                @(posedge clk); #1;
                check_outputs("post_done", 1'b0, 1'b0);
                break;
            end
            check_outputs("run", 1'b1, 1'b0);
            if (t > 20000) begin
                check("timeout", 64'd1, 64'd0);
                break;
            end
        end
    endtask

    initial begin
        int mag;
        int st;
        int ab;
        bus.cmd_valid      = 1'b0;
        bus.cmd_steps      = '0;
        bus.cmd_phase_time = '0;
        bus.counts_per_rev = '0;
        bus.abort          = 1'b0;
`ifdef QE_EMU_CONTINUOUS_EN
        bus.cmd_continuous = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        do_move(4, 10, 0, -1, 1'b0, 1'b0);
        do_move(-3, 0, 0, -1, 1'b0, 1'b0);
        do_move(9, 2, 4, -1, 1'b0, 1'b0);
        do_move(-1, 3, 4, -1, 1'b0, 1'b0);
        do_move(100, 5, 0, 7, 1'b0, 1'b0);
        do_move(0, 4, 0, -1, 1'b0, 1'b0);
        do_move(2, 3, 0, -1, 1'b0, 1'b1);
        do_move(5, 1, 0, 0, 1'b0, 1'b0);
        do_move(-6, 1, 3, -1, 1'b0, 1'b0);

        // Reset mid-move with cmd_valid held high throughout
        @(negedge clk);
        bus.cmd_valid      = 1'b1;
        bus.cmd_steps      = 32'd50;
        bus.cmd_phase_time = 24'd3;
        bus.counts_per_rev = 16'd0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        model_reset();
        check_outputs("reset_mid", 1'b0, 1'b0);
        @(posedge clk); #1;
        check_outputs("reset_hold", 1'b0, 1'b0);
        @(negedge clk);
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        check_outputs("reset_release", 1'b0, 1'b0);

        for (int k = 0; k < 14; k++) begin
            mag = int'($urandom_range(0, 12));
            st  = ($urandom_range(0, 1) == 1) ? -mag : mag;
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
            do_move(st, int'($urandom_range(0, 4)), ($urandom_range(0, 1) == 1) ? 7 : 0,
                    ab, 1'b0, 1'($urandom_range(0, 1)));
        end

`ifdef QE_EMU_CONTINUOUS_EN
        do_move(0, 2, 0, 9, 1'b1, 1'b0);
        do_move(-5, 1, 3, 6, 1'b1, 1'b0);
        do_move(3, 2, 0, 12, 1'b1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
